// File: rtl/avst_packet_gen.sv
// Avalon-ST packet source: bursts of fixed-length SOP/EOP-framed packets with an
// incrementing or constant payload, valid/ready backpressure and programmable idle gaps.
module avst_packet_gen #(
    parameter int DATA_W        = 32,
    parameter int EMPTY_W       = 2,
    parameter int WORDS_PER_PKT = 163,
    parameter int GAP_CYCLES    = 2,
    parameter int CNT_W         = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               abort,
    input  logic [CNT_W-1:0]   num_pkts,
    input  logic               mode,
    input  logic [DATA_W-1:0]  seed,
    output logic [DATA_W-1:0]  src_data,
    output logic               src_valid,
    input  logic               src_ready,
    output logic               src_sop,
    output logic               src_eop,
    output logic [EMPTY_W-1:0] src_empty,
    output logic               busy,
    output logic [CNT_W-1:0]   pkt_count
);

    localparam int BEAT_W = (WORDS_PER_PKT > 1) ? $clog2(WORDS_PER_PKT) : 1;
    localparam int GAP_W  = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(WORDS_PER_PKT - 1);
    localparam logic [GAP_W-1:0]  LAST_GAP  = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam logic ONE_BEAT = (WORDS_PER_PKT == 1) ? 1'b1 : 1'b0;
    localparam logic HAS_GAP  = (GAP_CYCLES > 0) ? 1'b1 : 1'b0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    state_t              state_r, state_s;
    logic [BEAT_W-1:0]   beat_r, beat_s;
    logic [GAP_W-1:0]    gap_r, gap_s;
    logic [CNT_W-1:0]    num_pkts_r, num_pkts_s;
    logic                mode_r, mode_s;
    logic [DATA_W-1:0]   seed_r, seed_s;
    logic                abort_pend_r, abort_pend_s;
    logic [DATA_W-1:0]   data_r, data_s;
    logic                valid_r, valid_s;
    logic                sop_r, sop_s;
    logic                eop_r, eop_s;
    logic                busy_r, busy_s;
    logic [CNT_W-1:0]    pkt_count_r, pkt_count_s;
    logic [CNT_W-1:0]    pkt_inc_s;
    logic                xfer_s;
    logic                stop_s;

    function automatic logic [DATA_W-1:0] beat_payload(
        input logic [DATA_W-1:0] base,
        input logic              const_mode,
        input logic [BEAT_W-1:0] beat
    );
        logic [DATA_W-1:0] val;
        if (const_mode) begin
            val = base;
        end else begin
            val = base + DATA_W'(beat);
        end
        return val;
    endfunction

    // Next-state and next-output computation for the IDLE/SEND/GAP sequencer
    always_comb begin
        state_s      = state_r;
        beat_s       = beat_r;
        gap_s        = gap_r;
        num_pkts_s   = num_pkts_r;
        mode_s       = mode_r;
        seed_s       = seed_r;
        abort_pend_s = abort_pend_r;
        data_s       = data_r;
        valid_s      = valid_r;
        sop_s        = sop_r;
        eop_s        = eop_r;
        pkt_count_s  = pkt_count_r;
        pkt_inc_s    = pkt_count_r + {{(CNT_W-1){1'b0}}, 1'b1};
        xfer_s       = valid_r & src_ready;
        stop_s       = 1'b0;

        case (state_r)
            ST_IDLE: begin
                abort_pend_s = 1'b0;
                valid_s      = 1'b0;
                sop_s        = 1'b0;
                eop_s        = 1'b0;
                if (start && !abort) begin
                    num_pkts_s  = num_pkts;
                    mode_s      = mode;
                    seed_s      = seed;
                    pkt_count_s = {CNT_W{1'b0}};
                    beat_s      = {BEAT_W{1'b0}};
                    data_s      = seed;
                    valid_s     = 1'b1;
                    sop_s       = 1'b1;
                    eop_s       = ONE_BEAT;
                    state_s     = ST_SEND;
                end else begin
                    state_s = ST_IDLE;
                end
            end

            ST_SEND: begin
                if (abort) begin
                    abort_pend_s = 1'b1;
                end else begin
                    abort_pend_s = abort_pend_r;
                end
                if (xfer_s) begin
                    if (beat_r == LAST_BEAT) begin
                        pkt_count_s = pkt_inc_s;
                        // An abort seen on the EOP beat itself also ends the burst here
                        stop_s = abort_pend_r | abort |
                                 ((num_pkts_r != {CNT_W{1'b0}}) && (pkt_inc_s == num_pkts_r));
                        beat_s = {BEAT_W{1'b0}};
                        if (stop_s) begin
                            state_s      = ST_IDLE;
                            abort_pend_s = 1'b0;
                            valid_s      = 1'b0;
                            sop_s        = 1'b0;
                            eop_s        = 1'b0;
                        end else if (HAS_GAP) begin
                            state_s = ST_GAP;
                            gap_s   = {GAP_W{1'b0}};
                            valid_s = 1'b0;
                            sop_s   = 1'b0;
                            eop_s   = 1'b0;
                        end else begin
                            state_s = ST_SEND;
                            data_s  = seed_r;
                            valid_s = 1'b1;
                            sop_s   = 1'b1;
                            eop_s   = ONE_BEAT;
                        end
                    end else begin
                        beat_s = beat_r + {{(BEAT_W-1){1'b0}}, 1'b1};
                        data_s = beat_payload(seed_r, mode_r, beat_s);
                        sop_s  = 1'b0;
                        eop_s  = (beat_s == LAST_BEAT) ? 1'b1 : 1'b0;
                    end
                end else begin
                    state_s = ST_SEND;
                end
            end

            ST_GAP: begin
                valid_s = 1'b0;
                if (abort) begin
                    state_s      = ST_IDLE;
                    abort_pend_s = 1'b0;
                end else if (gap_r == LAST_GAP) begin
                    state_s = ST_SEND;
                    beat_s  = {BEAT_W{1'b0}};
                    data_s  = seed_r;
                    valid_s = 1'b1;
                    sop_s   = 1'b1;
                    eop_s   = ONE_BEAT;
                end else begin
                    gap_s = gap_r + {{(GAP_W-1){1'b0}}, 1'b1};
                end
            end

            default: begin
                state_s      = ST_IDLE;
                abort_pend_s = 1'b0;
                valid_s      = 1'b0;
                sop_s        = 1'b0;
                eop_s        = 1'b0;
            end
        endcase

        busy_s = (state_s != ST_IDLE) ? 1'b1 : 1'b0;
    end

    // State and registered-output update with asynchronous clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_IDLE;
            beat_r       <= {BEAT_W{1'b0}};
            gap_r        <= {GAP_W{1'b0}};
            num_pkts_r   <= {CNT_W{1'b0}};
            mode_r       <= 1'b0;
            seed_r       <= {DATA_W{1'b0}};
            abort_pend_r <= 1'b0;
            data_r       <= {DATA_W{1'b0}};
            valid_r      <= 1'b0;
            sop_r        <= 1'b0;
            eop_r        <= 1'b0;
            busy_r       <= 1'b0;
            pkt_count_r  <= {CNT_W{1'b0}};
        end else begin
            state_r      <= state_s;
            beat_r       <= beat_s;
            gap_r        <= gap_s;
            num_pkts_r   <= num_pkts_s;
            mode_r       <= mode_s;
            seed_r       <= seed_s;
            abort_pend_r <= abort_pend_s;
            data_r       <= data_s;
            valid_r      <= valid_s;
            sop_r        <= sop_s;
            eop_r        <= eop_s;
            busy_r       <= busy_s;
            pkt_count_r  <= pkt_count_s;
        end
    end

    assign src_data  = data_r;
    assign src_valid = valid_r;
    assign src_sop   = sop_r;
    assign src_eop   = eop_r;
    assign src_empty = {EMPTY_W{1'b0}};
    assign busy      = busy_r;
    assign pkt_count = pkt_count_r;

endmodule

// File: tb/tb_avst_packet_gen.sv
// Directed bench for avst_packet_gen: table of burst scenarios plus hand sequences
// for single-beat packets, start+abort in IDLE and mid-packet reset.
module tb_avst_packet_gen;

    localparam int W      = 163;
    localparam int BUDGET = 5000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start_a, start_b, abort, mode, src_ready;
    logic [15:0] num_pkts;
    logic [31:0] seed;

    logic [31:0] data_a, data_b;
    logic        valid_a, sop_a, eop_a, busy_a;
    logic        valid_b, sop_b, eop_b, busy_b;
    logic [1:0]  empty_a, empty_b;
    logic [15:0] cnt_a, cnt_b;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    avst_packet_gen dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .abort(abort), .num_pkts(num_pkts),
        .mode(mode), .seed(seed), .src_data(data_a), .src_valid(valid_a), .src_ready(src_ready),
        .src_sop(sop_a), .src_eop(eop_a), .src_empty(empty_a), .busy(busy_a), .pkt_count(cnt_a)
    );

    avst_packet_gen #(.WORDS_PER_PKT(1), .GAP_CYCLES(0)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .abort(abort), .num_pkts(num_pkts),
        .mode(mode), .seed(seed), .src_data(data_b), .src_valid(valid_b), .src_ready(src_ready),
        .src_sop(sop_b), .src_eop(eop_b), .src_empty(empty_b), .busy(busy_b), .pkt_count(cnt_b)
    );

    typedef struct {
        logic [31:0] seed;
        logic        mode;
        logic [15:0] num;
        logic        rnd;
        int          ab_pkt;
        int          ab_beat;
        int          exp_beats;
        logic [31:0] exp_last;
        logic [15:0] exp_pkts;
    } vec_t;

    vec_t vecs[5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Run one burst on dut_a, checking every beat against seed/mode and the gap length
    task automatic run_vec(input vec_t v, input string tag);
        int          k = 0;
        int          pkt = 0;
        int          beats = 0;
        int          low_run = 0;
        int          cyc = 0;
        logic        prev_valid = 1'b0;
        logic [31:0] last = 32'd0;
        logic [31:0] exp_d;
        seed     = v.seed;
        mode     = v.mode;
        num_pkts = v.num;
        start_a  = 1'b1;
        step();
        start_a  = 1'b0;
        chk({tag, ":latency_valid"}, {31'd0, valid_a}, 32'd1);
        chk({tag, ":latency_sop"}, {31'd0, sop_a}, 32'd1);
        while (busy_a && cyc < BUDGET) begin
            src_ready  = v.rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            abort      = (valid_a && pkt == v.ab_pkt && k == v.ab_beat) ? 1'b1 : 1'b0;
            prev_valid = valid_a;
            if (valid_a) begin
                if (low_run != 0) begin
                    chk({tag, ":gap_len"}, 32'(low_run), 32'd2);
                end
                low_run = 0;
                exp_d = v.mode ? v.seed : v.seed + 32'(k);
                chk({tag, ":data"}, data_a, exp_d);
                chk({tag, ":sop"}, {31'd0, sop_a}, (k == 0) ? 32'd1 : 32'd0);
                chk({tag, ":eop"}, {31'd0, eop_a}, (k == W - 1) ? 32'd1 : 32'd0);
                if (src_ready) begin
                    last = data_a;
                    beats++;
                    k++;
                    if (k == W) begin
                        k = 0;
                        pkt++;
                    end
                end
            end else begin
                low_run++;
            end
            step();
            cyc++;
        end
        abort     = 1'b0;
        src_ready = 1'b1;
        chk({tag, ":no_timeout"}, (cyc < BUDGET) ? 32'd1 : 32'd0, 32'd1);
        chk({tag, ":beats"}, 32'(beats), 32'(v.exp_beats));
        chk({tag, ":last_data"}, last, v.exp_last);
        chk({tag, ":pkt_count"}, {16'd0, cnt_a}, {16'd0, v.exp_pkts});
        chk({tag, ":valid_off"}, {31'd0, valid_a}, 32'd0);
        chk({tag, ":busy_with_valid"}, {31'd0, prev_valid}, 32'd1);
    endtask

    initial begin
        vec_t rv;
        vecs[0] = '{32'd600000, 1'b0, 16'd2, 1'b0, -1, -1, 326, 32'd600162, 16'd2};
        vecs[1] = '{32'd600000, 1'b0, 16'd2, 1'b1, -1, -1, 326, 32'd600162, 16'd2};
        vecs[2] = '{32'hFFFFFFFE, 1'b0, 16'd1, 1'b0, -1, -1, 163, 32'h000000A0, 16'd1};
        vecs[3] = '{32'h12345678, 1'b1, 16'd1, 1'b1, -1, -1, 163, 32'h12345678, 16'd1};
        vecs[4] = '{32'd100, 1'b0, 16'd0, 1'b0, 2, 50, 489, 32'd262, 16'd3};

        rst_n = 1'b0; start_a = 1'b0; start_b = 1'b0; abort = 1'b0; mode = 1'b0;
        src_ready = 1'b1; num_pkts = 16'd0; seed = 32'd0;
        repeat (3) step();
        chk("rst_valid", {31'd0, valid_a}, 32'd0);
        chk("rst_busy", {31'd0, busy_a}, 32'd0);
        chk("rst_sop_eop", {30'd0, sop_a, eop_a}, 32'd0);
        chk("rst_data", data_a, 32'd0);
        chk("rst_count", {16'd0, cnt_a}, 32'd0);
        chk("rst_empty", {30'd0, empty_a}, 32'd0);
        rst_n = 1'b1;
        step();

        for (int i = 0; i < 5; i++) begin
            run_vec(vecs[i], $sformatf("vec%0d", i));
            repeat (2) step();
        end

        // start together with abort in IDLE must not launch a burst
        seed = 32'd9; num_pkts = 16'd1; start_a = 1'b1; abort = 1'b1;
        step();
        start_a = 1'b0; abort = 1'b0;
        chk("start_abort_valid", {31'd0, valid_a}, 32'd0);
        chk("start_abort_busy", {31'd0, busy_a}, 32'd0);

        // Single-beat packets, constant payload, back-to-back
        mode = 1'b1; seed = 32'hA5A5A5A5; num_pkts = 16'd4; src_ready = 1'b1; start_b = 1'b1;
        step();
        start_b = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("w1_valid", {31'd0, valid_b}, 32'd1);
            chk("w1_sop_eop", {30'd0, sop_b, eop_b}, 32'd3);
            chk("w1_data", data_b, 32'hA5A5A5A5);
            step();
        end
        chk("w1_end_valid", {31'd0, valid_b}, 32'd0);
        chk("w1_end_busy", {31'd0, busy_b}, 32'd0);
        chk("w1_count", {16'd0, cnt_b}, 32'd4);
        chk("w1_empty", {30'd0, empty_b}, 32'd0);

        // Asynchronous reset in the middle of a packet
        mode = 1'b0; seed = 32'h55; num_pkts = 16'd0; start_a = 1'b1;
        step();
        start_a = 1'b0;
        repeat (10) step();
        chk("mid_pre_valid", {31'd0, valid_a}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", {31'd0, valid_a}, 32'd0);
        chk("mid_rst_busy", {31'd0, busy_a}, 32'd0);
        chk("mid_rst_data", data_a, 32'd0);
        chk("mid_rst_sop_eop", {30'd0, sop_a, eop_a}, 32'd0);
        step();
        rst_n = 1'b1;
        step();
        rv = '{32'd7, 1'b0, 16'd1, 1'b0, -1, -1, 163, 32'd169, 16'd1};
        run_vec(rv, "post_rst");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
